// File: rtl/ram_1r1w_pkg.sv
// Playfield geometry shared by the evaluator and its row store.
package ram_1r1w_pkg;

    localparam int unsigned FIELD_WIDTH     = 10;
    localparam int unsigned FIELD_DEPTH     = 32;
    localparam int unsigned FIELD_ROWS_USED = 25;

endpackage

// File: rtl/ram_1r1w.sv
// Simple-dual-port flop array with a registered, read-first output port.
// All storage is resettable so no X ever reaches rd_data.
module ram_1r1w
    import ram_1r1w_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIELD_WIDTH,
    parameter int unsigned DEPTH      = FIELD_DEPTH,
    localparam int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_ok;
    logic                  rd_ok;

    always_comb begin
        wr_ok = wr_en && (32'(wr_addr) < DEPTH);
        rd_ok = (32'(rd_addr) < DEPTH);
    end

    // Read samples mem before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_addr] <= wr_data;
            end
            rd_data <= rd_ok ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_ram_1r1w.sv
// Directed bench for ram_1r1w at the playfield geometry (10 bits x 32 rows).
module tb_ram_1r1w;

    logic       clk;
    logic       rst_n;
    logic [4:0] rd_addr;
    logic [9:0] rd_data;
    logic [4:0] wr_addr;
    logic [9:0] wr_data;
    logic       wr_en;

    int unsigned n_checks;
    int unsigned n_fail;
    logic [9:0]  sweep_exp [32];

    ram_1r1w #(
        .DATA_WIDTH(10),
        .DEPTH     (32)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_en  (wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [9:0] actual, input logic [9:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 10'h%03h, expected 10'h%03h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [4:0] a, input logic [9:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_en    = 1'b0;

        #2;
        check_eq("reset_initial", rd_data, 10'h000);
        tick();
        tick();
        rst_n = 1'b1;

        // Reset mid-run: contents written before reset must be cleared
        write_word(5'd5, 10'h3FF);
        rd_addr = 5'd5;
        tick();
        check_eq("pre_reset_read5", rd_data, 10'h3FF);
        rst_n = 1'b0;
        #1;
        check_eq("reset_async_rd", rd_data, 10'h000);
        wr_en   = 1'b1;
        wr_addr = 5'd6;
        wr_data = 10'h111;
        tick();
        check_eq("reset_hold_rd", rd_data, 10'h000);
        wr_en = 1'b0;
        rst_n = 1'b1;
        rd_addr = 5'd5;
        tick();
        check_eq("post_reset_read5", rd_data, 10'h000);
        rd_addr = 5'd6;
        tick();
        check_eq("write_during_reset_ignored", rd_data, 10'h000);

        // Latency: data appears exactly one edge after rd_addr is sampled
        rd_addr = 5'd0;
        write_word(5'd3, 10'h2A5);
        check_eq("latency_not_early", rd_data, 10'h000);
        rd_addr = 5'd3;
        tick();
        check_eq("latency_read3", rd_data, 10'h2A5);
        #4;
        check_eq("hold_between_edges", rd_data, 10'h2A5);

        // Read-during-write to the same address returns old data
        write_word(5'd7, 10'h001);
        rd_addr = 5'd7;
        write_word(5'd7, 10'h3C0);
        check_eq("rdw_old_data", rd_data, 10'h001);
        tick();
        check_eq("rdw_new_data", rd_data, 10'h3C0);

        // Write enable low must not modify the array
        wr_en   = 1'b0;
        wr_addr = 5'd9;
        wr_data = 10'h155;
        rd_addr = 5'd0;
        tick();
        rd_addr = 5'd9;
        tick();
        check_eq("wr_en_low_read9", rd_data, 10'h000);

        // Full sweep: address * 33, masked to 10 bits
        for (int i = 0; i < 32; i++) begin
            sweep_exp[i] = 10'((i * 33) & 10'h3FF);
            write_word(5'(i), sweep_exp[i]);
        end
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            tick();
            check_eq($sformatf("sweep_%0d", i), rd_data, sweep_exp[i]);
        end
        check_eq("sweep_last_all_ones", rd_data, 10'h3FF);

        // Concurrent ports on different addresses are independent
        write_word(5'd11, 10'h00F);
        rd_addr = 5'd11;
        write_word(5'd12, 10'h0F0);
        check_eq("concurrent_read11", rd_data, 10'h00F);
        rd_addr = 5'd12;
        tick();
        check_eq("concurrent_read12", rd_data, 10'h0F0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
